// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one read per instruction, holds the fetched word
// until the decoder accepts it, then advances or redirects the PC.
module fetch_unit #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  output logic [31:0]     fetch_count
);

  localparam logic [XLEN-1:0] Nop = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StValid} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [31:0]     fetch_count_q, fetch_count_d;
  logic            imem_req_q, imem_req_d;
  logic            instr_valid_q, instr_valid_d;
  logic            handshake;
  logic [XLEN-1:0] target_aligned;
  logic            unused_target_lsbs;

  assign handshake          = instr_valid_q & instr_ready;
  assign target_aligned     = {pc_target[XLEN-1:2], 2'b00};
  assign unused_target_lsbs = ^pc_target[1:0];

  // imem_req and instr_valid are registered copies of the state they belong to, so they
  // are computed from the state being entered rather than decoded from state_q.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    fetch_count_d = fetch_count_q;
    imem_req_d    = 1'b0;
    instr_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        state_d    = StReq;
        imem_req_d = 1'b1;
      end
      StReq: begin
        state_d = StWait;
      end
      StWait: begin
        if (imem_rvalid) begin
          instr_d       = imem_rdata;
          state_d       = StValid;
          instr_valid_d = 1'b1;
        end
      end
      StValid: begin
        if (handshake) begin
          pc_d          = pc_src ? target_aligned : pc_q + XLEN'(4);
          fetch_count_d = fetch_count_q + 32'd1;
          state_d       = StReq;
          imem_req_d    = 1'b1;
        end else begin
          instr_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      instr_q       <= Nop;
      fetch_count_q <= 32'd0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      fetch_count_q <= fetch_count_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + XLEN'(4);
  assign instr_valid = instr_valid_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning: PC value loaded on reset; bits [1:0] SHALL be zero.
REQ-002 Parameter XLEN, default 32, meaning: width of PC, address and instruction datapaths.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 imem_req  output  1  instruction memory read request, one-cycle pulse.
REQ-006 imem_addr  output  32  word-aligned read address, valid while imem_req=1.
REQ-007 imem_rvalid  input  1  read data valid; arrives at least 1 cycle after imem_req; one outstanding read at most.
REQ-008 imem_rdata  input  32  instruction word, sampled when imem_rvalid=1.
REQ-009 instr  output  32  fetched instruction presented to the controller/datapath decode.
REQ-010 pc  output  32  address of instr.
REQ-011 pc_plus4  output  32  pc + 4, modulo 2^32, for jal/jalr link write-back.
REQ-012 instr_valid  output  1  instr/pc/pc_plus4 hold a valid instruction.
REQ-013 instr_ready  input  1  downstream accepts instr this cycle.
REQ-014 pc_src  input  1  redirect select from the controller ((branch AND zero) OR jump).
REQ-015 pc_target  input  32  branch/jump target address from the datapath.
REQ-016 fetch_count  output  32  number of instructions accepted downstream.

Function
REQ-017 FSM states: IDLE, REQ, WAIT, VALID; encoding is free.
REQ-018 IDLE: outputs quiet; the next state is unconditionally REQ (one idle cycle after reset release).
REQ-019 REQ: imem_req=1, imem_addr=pc for exactly one cycle; the next state is WAIT.
REQ-020 WAIT: imem_req=0; on imem_rvalid=1 capture imem_rdata into instr and go to VALID; otherwise remain, with no timeout.
REQ-021 VALID: instr_valid=1; instr, pc and pc_plus4 stable until handshake (instr_valid AND instr_ready).
REQ-022 On handshake: pc <= pc_src ? {pc_target[31:2],2'b00} : pc+4; fetch_count increments by 1; the next state is REQ.
REQ-023 pc_src and pc_target are sampled only in the handshake cycle; their values in any other cycle have no effect.
REQ-024 pc_target[1:0] are ignored (forced to 00); no misalignment exception is raised.
REQ-025 PC arithmetic is modulo 2^32: pc 32'hFFFF_FFFC with pc_src=0 wraps to 32'h0000_0000.
REQ-026 fetch_count wraps from 32'hFFFF_FFFF to 0 with no flag.
REQ-027 imem_rvalid received outside WAIT is ignored; instr is not modified.
REQ-028 Minimum throughput: one instruction per 3 cycles (REQ, WAIT with rvalid on the first WAIT cycle, VALID with instr_ready=1).
REQ-029 instr_valid is 0 in IDLE, REQ and WAIT.
REQ-030 All outputs are driven from registers, except pc_plus4 (pc+4) and imem_addr (pc).

Reset
REQ-031 When rst_n=0 at a clock edge: state=IDLE, pc=RESET_PC, instr=32'h0000_0013 (nop), fetch_count=0, instr_valid=0, imem_req=0.
REQ-032 Reset in any state, including WAIT with a read outstanding, SHALL abort the operation; the instruction memory shares rst_n, so no stale response follows.
REQ-033 Reset has priority over a handshake occurring in the same cycle: pc and fetch_count take their reset values.

Verification
REQ-034 Reset release with RESET_PC=0, memory returning rvalid 1 cycle after req, instr_ready held 1 -> imem_req pulses with addr 0, 4, 8, one every 3 cycles; fetch_count increments 1, 2, 3.
REQ-035 instr_ready=0 for 5 cycles in VALID -> instr, pc and pc_plus4 stable and no imem_req; after ready=1, next request goes to pc+4.
REQ-036 Handshake at pc=0x10 with pc_src=1, pc_target=0x0000_0103 -> next imem_addr=0x0000_0100; pc_src=1 pulsed during WAIT only -> no redirect, next addr=0x14.
REQ-037 RESET_PC=0xFFFF_FFFC, one handshake with pc_src=0 -> next imem_addr=0x0000_0000 and pc_plus4 before the handshake reads 0x0000_0000.
REQ-038 rst_n=0 while in WAIT at pc=0x40 -> next cycle state IDLE, pc=RESET_PC, instr=0x0000_0013, instr_valid=0, fetch_count=0; a spurious rvalid in IDLE leaves instr unchanged.
